// File: rtl/if_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package if_pkg;

    localparam logic [31:0] NOP_CODE = 32'h0;
    localparam int unsigned PC_INCR  = 4;

    // Width of a read/write pointer into a queue of the given depth.
    function automatic int unsigned qptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Decode-side handshake of the fetch stage: redirect/stall in, head entry out.
interface if_prefetch_queue_if #(
    parameter int unsigned NB_DATA    = 32,
    parameter int unsigned NB_ADDRESS = 32
) ();

    logic                  i_branch;
    logic [NB_ADDRESS-1:0] i_branch_addr;
    logic                  i_stall;
    logic [NB_DATA-1:0]    o_instruction;
    logic [NB_ADDRESS-1:0] o_next_pc_1;
    logic                  o_valid;
    logic                  o_fetch_error;

    // Decode side: drives redirects and stalls, consumes instructions.
    modport master (
        output i_branch, i_branch_addr, i_stall,
        input  o_instruction, o_next_pc_1, o_valid, o_fetch_error
    );

    // Fetch side.
    modport slave (
        input  i_branch, i_branch_addr, i_stall,
        output o_instruction, o_next_pc_1, o_valid, o_fetch_error
    );

endinterface

// File: rtl/if_queue.sv
// Synchronous FIFO with flush; power-of-two depth so pointers wrap naturally.
module if_queue
    import if_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_data,
    output logic [qptr_width(DEPTH):0]   o_count,
    output logic                         o_empty
);

    localparam int unsigned PtrW = qptr_width(DEPTH);
    localparam logic [PtrW:0] CountFull = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW:0]    count;
    logic [PtrW:0]    count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Guarded push/pop and next occupancy.
    always_comb begin
        full    = (count == CountFull);
        do_pop  = i_pop & (count != '0);
        do_push = i_push & (~full | do_pop);
        count_d = count;
        case ({do_push, do_pop})
            2'b10:   count_d = count + 1'b1;
            2'b01:   count_d = count - 1'b1;
            default: count_d = count;
        endcase
    end

    // Pointers and occupancy; flush empties the queue without touching storage.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_d;
        end
    end

    // Entry storage, not reset.
    always_ff @(posedge i_clk) begin
        if (do_push) storage[wr_ptr] <= i_data;
    end

    assign o_data  = storage[rd_ptr];
    assign o_count = count;
    assign o_empty = (count == '0);

endmodule

// File: rtl/rom_memory32.sv
// Program memory: one-cycle synchronous read of a word-indexed image.
module rom_memory32 #(
    parameter int unsigned NB_DATA   = 32,
    parameter int unsigned N_WORDS   = 128,
    parameter int unsigned NB_ADDR   = 7,
    parameter              INIT_FILE = ""
) (
    input  logic               i_clk,
    input  logic               i_rd_en,
    input  logic [NB_ADDR-1:0] i_addr,
    output logic [NB_DATA-1:0] o_data
);

    // Without a file the ROM serves the built-in boot image (word n = 0x11 + n);
    // file images are placed by the back-end memory flow and read as NOP here.
    localparam bit UseBuiltin = (INIT_FILE == "");

    function automatic logic [NB_DATA-1:0] image_word(input logic [NB_ADDR-1:0] addr);
        if (UseBuiltin && (32'(addr) < N_WORDS)) begin
            return NB_DATA'(32'h11) + NB_DATA'(addr);
        end
        return '0;
    endfunction

    // Registered read, issued only when the fetch stage asks.
    always_ff @(posedge i_clk) begin
        if (i_rd_en) o_data <= image_word(i_addr);
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Fetch stage: sequential PC prefetch into a queue, branch flush, sticky
// misaligned-target error. Outputs come straight from queue storage.
module if_prefetch_queue
    import if_pkg::*;
#(
    parameter int unsigned NB_DATA         = 32,
    parameter int unsigned NB_ADDRESS      = 32,
    parameter int unsigned N_MEM_ADDRESS   = 128,
    parameter int unsigned NB_MEM_ADDRESS  = $clog2(N_MEM_ADDRESS) + 2,
    parameter int unsigned QUEUE_DEPTH     = 4,
    parameter logic [NB_ADDRESS-1:0] RESET_PC = '0,
    parameter              INIT_FILE       = ""
) (
    input  logic            i_clk,
    input  logic            i_reset,
    if_prefetch_queue_if.slave bus
);

    localparam int unsigned PtrW      = qptr_width(QUEUE_DEPTH);
    localparam int unsigned NbRomAddr = NB_MEM_ADDRESS - 2;
    localparam int unsigned NbEntry   = NB_DATA + NB_ADDRESS;

    logic [NB_ADDRESS-1:0] pc_q, pc_d;
    logic [NB_ADDRESS-1:0] link_q, link_d;   // PC+4 of the read in flight
    logic                  inflight_q, inflight_d;
    logic                  err_q, err_d;

    logic [NB_ADDRESS-1:0] fetch_pc;
    logic                  misaligned;
    logic                  space;
    logic                  rom_en;
    logic [NbRomAddr-1:0]  rom_addr;
    logic [NB_DATA-1:0]    rom_data;
    logic                  push;
    logic                  pop;
    logic [PtrW:0]         q_count;
    logic                  q_empty;
    logic [NbEntry-1:0]    q_head;

    // Issue, redirect and error decisions. An aligned branch issues its target
    // in the same cycle so the target reaches decode two cycles later.
    always_comb begin
        misaligned = (bus.i_branch_addr[1:0] != 2'b00);
        fetch_pc   = bus.i_branch ? bus.i_branch_addr : pc_q;
        pop        = ~q_empty & ~bus.i_stall & ~bus.i_branch;
        push       = inflight_q & ~bus.i_branch;
        space      = (32'(q_count) + 32'(inflight_q)) < QUEUE_DEPTH;
        rom_en     = bus.i_branch ? ~misaligned : (~err_q & space);
        rom_addr   = fetch_pc[NB_MEM_ADDRESS-1:2];

        pc_d       = pc_q;
        link_d     = link_q;
        inflight_d = rom_en;
        err_d      = err_q;
        if (rom_en) begin
            pc_d   = fetch_pc + NB_ADDRESS'(PC_INCR);
            link_d = pc_d;
        end
        if (bus.i_branch) begin
            err_d = misaligned;
            if (misaligned) pc_d = bus.i_branch_addr;
        end
    end

    // Fetch state registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q       <= RESET_PC;
            link_q     <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            link_q     <= link_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    rom_memory32 #(
        .NB_DATA   (NB_DATA),
        .N_WORDS   (N_MEM_ADDRESS),
        .NB_ADDR   (NbRomAddr),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .i_clk   (i_clk),
        .i_rd_en (rom_en),
        .i_addr  (rom_addr),
        .o_data  (rom_data)
    );

    if_queue #(
        .WIDTH (NbEntry),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (bus.i_branch),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  ({rom_data, link_q}),
        .o_data  (q_head),
        .o_count (q_count),
        .o_empty (q_empty)
    );

    assign bus.o_valid       = ~q_empty;
    assign bus.o_instruction = q_empty ? NB_DATA'(NOP_CODE) : q_head[NbEntry-1 -: NB_DATA];
    assign bus.o_next_pc_1   = q_empty ? '0 : q_head[NB_ADDRESS-1:0];
    assign bus.o_fetch_error = err_q;

endmodule

// File: doc/if_prefetch_queue.md
# if_prefetch_queue

Parametrised instruction-fetch stage with a decoupling prefetch queue between program memory and decode. The PC issues sequential word reads to a synchronous ROM whenever queue space is available; returned instructions are buffered with their PC+4 and presented to decode through a valid/stall handshake. Branches flush the queue and any in-flight read, and misaligned branch targets raise a sticky fetch error instead of fetching.

## Interface
- NB_DATA, 32, instruction width
- NB_ADDRESS, 32, byte-address width
- N_MEM_ADDRESS, 128, program memory depth in words
- NB_MEM_ADDRESS, $clog2(N_MEM_ADDRESS)+2, byte-address bits used to index memory
- QUEUE_DEPTH, 4, prefetch entries; power of two, ≥4
- RESET_PC, 0, PC loaded on reset; word-aligned
- INIT_FILE, "", program memory init file

- i_clk  in  1  single clock, all state updates on rising edge
- i_reset  in  1  synchronous, active-high
- i_branch  in  1  redirect fetch this cycle
- i_branch_addr  in  NB_ADDRESS  redirect target (byte address)
- i_stall  in  1  decode not ready; head not consumed
- o_instruction  out  NB_DATA  head instruction; NOP (0) when o_valid=0
- o_next_pc_1  out  NB_ADDRESS  PC+4 of head instruction; 0 when o_valid=0
- o_valid  out  1  head entry valid
- o_fetch_error  out  1  sticky misaligned-target flag

## Operation
- Pop = o_valid & ~i_stall & ~i_branch. Push = in-flight read returning and not discarded.
- Issue: when count + inflight < QUEUE_DEPTH, no error, no branch: read ROM at pc[NB_MEM_ADDRESS-1:2], set inflight, pc <= pc+4 (NB_ADDRESS wrap-around, no saturation).
- At most one read in flight (ROM latency 1); entry stores {instruction, issued_pc+4}.
- Branch (priority over stall and issue): queue cleared, inflight discarded, pc <= i_branch_addr. If i_branch_addr[1:0]≠0: o_fetch_error <= 1, no issue until next aligned branch or reset.
- Aligned branch clears o_fetch_error.
- Queue full with stall: issue stops, contents held; no overwrite, no drop.
- Pop and push same cycle: count unchanged, ordering preserved.
- Reset mid-operation: same as power-on reset; in-flight data discarded.

## Timing
- Reset values: pc=RESET_PC, queue empty, inflight=0, o_valid=0, o_instruction=0, o_next_pc_1=0, o_fetch_error=0.
- Cycle 0 = first cycle with i_reset low: read issued to RESET_PC; data captured into queue at end of cycle 1; o_valid=1 in cycle 2.
- Branch in cycle B: o_valid=0 in B+1; target instruction on o_valid in B+2.
- Steady state, no stall: one instruction per cycle, queue holds 1 entry.
- Stall asserted k cycles: head held stable; queue fills to QUEUE_DEPTH then issue halts; resumes one cycle after first pop.
- Outputs are registered/queue-storage driven; no combinational path from inputs to outputs.

## Structure
- Shared package if_pkg: NOP_CODE (32'h0), PC_INCR (4), function for queue pointer width ($clog2(QUEUE_DEPTH)).
- Sub-module if_queue: synchronous FIFO with push/pop/flush, count output, width NB_DATA+NB_ADDRESS.
- Program memory instantiated as existing rom_memory32 with read enable tied to issue.

## Test plan
- Reset release, INIT_FILE words 0x11..0x18, no stall -> o_valid from cycle 2, o_instruction 0x11,0x12,… one per cycle, o_next_pc_1 4,8,12…
- Stall held 6 cycles from cycle 3 -> head 0x12 constant, count reaches 4, no issue while full; after release 0x13..0x16 in order, no gaps beyond one cycle.
- Branch to 0x20 at cycle 5 with queue partly full -> o_valid=0 cycle 6, cycle 7 shows word 8 with o_next_pc_1=0x24; pre-branch entries never appear.
- Branch to 0x22 -> o_fetch_error=1, o_valid stays 0; later branch to 0x10 -> error clears, word 4 appears 2 cycles later.
- Branch and stall asserted together while full -> flush wins, redirect timing as above.
- Reset asserted while read in flight and queue full -> next cycle all outputs at reset values; refetch from RESET_PC.
